// File: rtl/mod3_pkg.sv
// Shared definitions for the serial divisible-by-3 transmit/detect pair:
// FSM state encoding, the 2-bit residue type and the residue step function.
package mod3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic [1:0] residue_t;

  localparam residue_t RES0 = 2'd0;
  localparam residue_t RES1 = 2'd1;
  localparam residue_t RES2 = 2'd2;

  // Appending bit b to a value with residue r gives residue (2r + b) mod 3.
  function automatic residue_t res_next(input residue_t r, input logic b);
    residue_t n;
    case (r)
      RES0:    n = b ? RES1 : RES0;
      RES1:    n = b ? RES0 : RES2;
      RES2:    n = b ? RES2 : RES1;
      default: n = RES0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mod3_residue.sv
// Running residue mod 3 of an MSB-first bit stream. Shared with the
// detector side so both ends step the residue identically.
module mod3_residue
  import mod3_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     clear_i,
  input  logic     step_i,
  input  logic     bit_i,
  output residue_t residue_o,
  output logic     div3_o
);

  residue_t res_q;

  // Residue register: clear wins over step so a new frame always starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= RES0;
    end else if (clear_i) begin
      res_q <= RES0;
    end else if (step_i) begin
      res_q <= res_next(res_q, bit_i);
    end
  end

  assign residue_o = res_q;
  assign div3_o    = (res_q == RES0);

endmodule

// File: rtl/mod3_serial_tx.sv
// Transmit side of the serial divisible-by-3 stream. Accepts a word and a
// bit count, emits one framing reset pulse, shifts the word out MSB-first
// and publishes the expected divisibility verdict at the end of the frame.
// Optional macro MOD3_CHECK_EN adds det_res_i / mismatch_o to compare the
// detector's verdict against the locally tracked residue.
module mod3_serial_tx
  import mod3_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             ready_o,
  output logic             ser_reset_o,
  output logic             ser_bit_o,
  output logic             ser_valid_o,
  output logic             done_o,
  output logic             exp_div3_o
`ifdef MOD3_CHECK_EN
  ,
  input  logic             det_res_i,
  output logic             mismatch_o
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             exp_q, exp_d;

  logic             resClear;
  logic             resStep;
  logic             serBit;
  residue_t         residue;
  logic             resDiv3;

  assign serBit = data_q[cnt_q];

  mod3_residue u_residue (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (resClear),
    .step_i    (resStep),
    .bit_i     (serBit),
    .residue_o (residue),
    .div3_o    (resDiv3)
  );

  // State and datapath registers; reset mid-frame abandons the frame outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
    end
  end

  // Next-state logic: sequences IDLE -> SYNC -> SHIFT* -> DONE and captures
  // the verdict on the edge that enters DONE so it is valid with done_o.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    resClear = 1'b0;
    resStep  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          data_d   = data_i;
          len_d    = (len_i > LEN_MAX) ? LEN_MAX : len_i;
          exp_d    = 1'b0;
          resClear = 1'b1;
          state_d  = SYNC;
        end
      end
      SYNC: begin
        if (len_q == '0) begin
          exp_d   = resDiv3;
          state_d = DONE;
        end else begin
          cnt_d   = CNT_W'(len_q - LEN_W'(1));
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        resStep = 1'b1;
        if (cnt_q == '0) begin
          exp_d   = (res_next(residue, serBit) == RES0);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from registered state only, so inputs never reach outputs.
  always_comb begin
    ready_o     = 1'b0;
    ser_reset_o = 1'b0;
    ser_bit_o   = 1'b0;
    ser_valid_o = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      IDLE:    ready_o = 1'b1;
      SYNC:    ser_reset_o = 1'b1;
      SHIFT: begin
        ser_bit_o   = serBit;
        ser_valid_o = 1'b1;
      end
      DONE:    done_o = 1'b1;
      default: ready_o = 1'b0;
    endcase
  end

  assign exp_div3_o = exp_q;

`ifdef MOD3_CHECK_EN
  logic mismatch_q;

  // Sticky flag: any frame where the detector disagrees with the local residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_q <= 1'b0;
    end else if ((state_q == DONE) && (det_res_i != resDiv3)) begin
      mismatch_q <= 1'b1;
    end
  end

  assign mismatch_o = mismatch_q;
`endif

endmodule
